// File: rtl/round_robin_lock_arbiter_if.sv
// Request/grant bus between requesters and round_robin_lock_arbiter.
// master: requester side (drives req_i/ack_i); slave: arbiter side.
interface round_robin_lock_arbiter_if #(
  parameter int unsigned N = 32
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  req_i;
  logic          ack_i;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          gnt_valid_o;

  modport master (
    output req_i,
    output ack_i,
    input  gnt_o,
    input  gnt_idx_o,
    input  gnt_valid_o
  );

  modport slave (
    input  req_i,
    input  ack_i,
    output gnt_o,
    output gnt_idx_o,
    output gnt_valid_o
  );
endinterface

// File: rtl/round_robin_lock_arbiter.sv
// Round-robin arbiter with grant lock: a grant is held until the grantee
// acks or drops its request, then re-arbitration happens in the same edge.
// Optional macro ARB_HOLD_LIMIT_EN adds a forced release after MAX_HOLD
// grant cycles.
module round_robin_lock_arbiter #(
  parameter int unsigned N        = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic                        clk,
  input logic                        reset,
  round_robin_lock_arbiter_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;

  logic          force_rel;
  logic          release_ev;
  logic          arbitrate;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] search_ptr;
  logic [N-1:0]  eligible;
  logic          win_found;
  logic [IW-1:0] win_idx;
  int unsigned   k;

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;

  // Forced release once the current grant has been visible MAX_HOLD cycles
  always_comb begin
    force_rel = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD - 1));
  end
`else
  always_comb begin
    force_rel = 1'b0;
  end
`endif

  // Release detection and the request set / start pointer for this edge
  always_comb begin
    next_ptr   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    release_ev = 1'b0;
    arbitrate  = 1'b0;
    search_ptr = ptr_q;
    eligible   = '0;
    if (state_q == IDLE) begin
      arbitrate = 1'b1;
      eligible  = bus.req_i;
    end else begin
      release_ev = bus.ack_i || !bus.req_i[idx_q] || force_rel;
      if (release_ev) begin
        arbitrate  = 1'b1;
        search_ptr = next_ptr;
        eligible   = bus.req_i;
        // A forced release excludes the grantee unless it is the only requester
        if (force_rel && ((bus.req_i & ~gnt_q) != '0))
          eligible = bus.req_i & ~gnt_q;
      end
    end
  end

  // First eligible requester at or above search_ptr, wrapping past N-1
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(search_ptr) + i) % N;
      if (!win_found && eligible[k[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = k[IW-1:0];
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
    if (state_q == GRANT && !release_ev)
      hold_d = hold_q + 8'd1;
`endif
    if (release_ev)
      ptr_d = next_ptr;
    if (arbitrate) begin
`ifdef ARB_HOLD_LIMIT_EN
      hold_d = '0;
`endif
      if (win_found) begin
        state_d          = GRANT;
        gnt_d            = '0;
        gnt_d[win_idx]   = 1'b1;
        idx_d            = win_idx;
        valid_d          = 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  // State and output registers; reset overrides any arbitration
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = valid_q;
endmodule

// File: tb/tb_round_robin_lock_arbiter.sv
// Self-checking bench for round_robin_lock_arbiter (N=4, MAX_HOLD=3).
// Honours ARB_HOLD_LIMIT_EN the same way as the design.
module tb_round_robin_lock_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 3;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  // Reference model state: owner = granted requester or -1
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  round_robin_lock_arbiter_if #(.N(N)) bus ();

  round_robin_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [N-1:0] cand, int start);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (start + i) % N;
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  // Applies one clock edge of the arbitration rules to the model
  function automatic void model_step(logic rst, logic [N-1:0] req, logic ack);
    bit released, forced;
    logic [N-1:0] cand;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
      return;
    end
    if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
      m_held  = 1;
      return;
    end
    forced = 0;
`ifdef ARB_HOLD_LIMIT_EN
    forced = (m_held >= MAX_HOLD);
`endif
    released = ack || !req[m_owner] || forced;
    if (!released) begin
      m_held++;
      return;
    end
    cand = req;
    if (forced && ((req & ~(4'b1 << m_owner)) != 0))
      cand = req & ~(4'b1 << m_owner);
    m_ptr   = (m_owner + 1) % N;
    m_owner = pick(cand, m_ptr);
    m_held  = 1;
  endfunction

  task automatic check_model(string tag);
    logic [N-1:0] e_gnt;
    logic [1:0]   e_idx;
    logic         e_val;
    e_gnt = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
    e_idx = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e_val = (m_owner >= 0);
    tests++;
    assert (bus.gnt_o === e_gnt) else begin
      fails++;
      $error("FAIL %s gnt_o got %b expected %b", tag, bus.gnt_o, e_gnt);
    end
    tests++;
    assert (bus.gnt_idx_o === e_idx) else begin
      fails++;
      $error("FAIL %s gnt_idx_o got %0d expected %0d", tag, bus.gnt_idx_o, e_idx);
    end
    tests++;
    assert (bus.gnt_valid_o === e_val) else begin
      fails++;
      $error("FAIL %s gnt_valid_o got %b expected %b", tag, bus.gnt_valid_o, e_val);
    end
    tests++;
    assert ($countones(bus.gnt_o) <= 1) else begin
      fails++;
      $error("FAIL %s onehot got %b expected at most one bit", tag, bus.gnt_o);
    end
  endtask

  task automatic check_const(string tag, logic [N-1:0] e_gnt);
    tests++;
    assert (bus.gnt_o === e_gnt) else begin
      fails++;
      $error("FAIL %s gnt_o got %b expected %b", tag, bus.gnt_o, e_gnt);
    end
  endtask

  // One clock: model sees the inputs present at the edge, outputs sampled #1 later
  task automatic step(string tag);
    @(posedge clk);
    model_step(reset, bus.req_i, bus.ack_i);
    #1;
    check_model(tag);
  endtask

  logic [N-1:0] seq030 [5];
  logic [N-1:0] seq033 [8];

  initial begin
    seq030[0] = 4'b0001; seq030[1] = 4'b0010; seq030[2] = 4'b0100;
    seq030[3] = 4'b1000; seq030[4] = 4'b0001;
`ifdef ARB_HOLD_LIMIT_EN
    seq033[0] = 4'b0001; seq033[1] = 4'b0001; seq033[2] = 4'b0001;
    seq033[3] = 4'b0010; seq033[4] = 4'b0010; seq033[5] = 4'b0010;
    seq033[6] = 4'b0001; seq033[7] = 4'b0001;
`else
    for (int i = 0; i < 8; i++) seq033[i] = 4'b0001;
`endif

    // Reset held two cycles with all requests active
    reset = 1'b1; bus.req_i = 4'b1111; bus.ack_i = 1'b0;
    step("reset0"); check_const("reset0_c", 4'b0000);
    step("reset1"); check_const("reset1_c", 4'b0000);
    reset = 1'b0;

    // Full rotation with ack every grant cycle, no bubbles
    step("first"); check_const("first_c", seq030[0]);
    bus.ack_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step("rotate"); check_const("rotate_c", seq030[i]);
    end

    // Sole requester stays granted across acks
    bus.req_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step("sole"); check_const("sole_c", 4'b0100);
    end

    // Lock, then release by dropped request jumps to next requester
    bus.req_i = 4'b0010;
    step("get1"); check_const("get1_c", 4'b0010);
    bus.ack_i = 1'b0; bus.req_i = 4'b1011;
    step("lock1"); check_const("lock1_c", 4'b0010);
    bus.req_i = 4'b1001;
    step("drop1"); check_const("drop1_c", 4'b1000);
    bus.req_i = 4'b0000;
    step("toidle"); check_const("toidle_c", 4'b0000);

    // ack while idle is ignored
    bus.ack_i = 1'b1;
    step("idleack0"); check_const("idleack0_c", 4'b0000);
    step("idleack1"); check_const("idleack1_c", 4'b0000);

    // Two competing requesters, never acked
    bus.ack_i = 1'b0; bus.req_i = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step("hold"); check_const("hold_c", seq033[i]);
    end

    // Reset mid-grant restores ptr to 0
    bus.ack_i = 1'b1; bus.req_i = 4'b0000;
    step("clear");
    bus.ack_i = 1'b0; bus.req_i = 4'b0100;
    step("g2"); check_const("g2_c", 4'b0100);
    reset = 1'b1; bus.req_i = 4'b1111;
    step("midrst"); check_const("midrst_c", 4'b0000);
    reset = 1'b0;
    step("postrst"); check_const("postrst_c", 4'b0001);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.req_i = 4'($urandom_range(0, 15));
      bus.ack_i = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
